// File: rtl/nonce_sweep_ctrl.sv
// Nonce sweep controller: reads the header tail, runs phase-2/phase-3 hashes per nonce, stores digest word 0.
// Optional target comparison (found / found_nonce) is enabled by defining NONCE_TARGET_CMP_EN.
module nonce_sweep_ctrl #(
    parameter int          NUM_NONCES = 16,
    parameter logic [15:0] TAIL_ADDR  = 16'd16,
    parameter logic [15:0] OUT_ADDR   = 16'd32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0][31:0] midstate,
    output logic             done,
    output logic [15:0]      mem_addr,
    output logic             mem_we,
    output logic [31:0]      mem_write_data,
    input  logic [31:0]      mem_read_data,
    output logic             core_start,
    output logic             core_phase_sel,
    output logic [3:0]       core_nonce,
    output logic [7:0][31:0] core_hi,
    output logic [2:0][31:0] core_msg_tail,
    input  logic [7:0][31:0] core_ho,
    input  logic             core_finish
`ifdef NONCE_TARGET_CMP_EN
    ,
    input  logic [31:0]      target,
    output logic             found,
    output logic [3:0]       found_nonce
`endif
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD0, S_RD1, S_RD2, S_RDW,
        S_P2_GO, S_P2_WAIT, S_P3_GO, S_P3_WAIT, S_WR, S_DONE
    } state_t;

    localparam logic [3:0] LAST_NONCE = 4'(NUM_NONCES - 1);

    state_t           state_q;
    logic [7:0][31:0] midstate_q;
    logic [7:0][31:0] hi_q;
    logic [2:0][31:0] tail_q;
    logic [3:0]       nonce_q;
    logic [3:0]       nonce_d;
    logic             done_q;
    logic             we_q;
    logic [15:0]      addr_q;
    logic [31:0]      wdata_q;
    logic             cstart_q;
    logic             phase_q;
`ifdef NONCE_TARGET_CMP_EN
    logic             found_q;
    logic [3:0]       found_nonce_q;
`endif

    assign nonce_d = nonce_q + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            midstate_q <= '0;
            hi_q       <= '0;
            tail_q     <= '0;
            nonce_q    <= '0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cstart_q   <= 1'b1;
            phase_q    <= 1'b0;
`ifdef NONCE_TARGET_CMP_EN
            found_q       <= 1'b0;
            found_nonce_q <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    cstart_q <= 1'b1;
                    done_q   <= 1'b0;
                    if (start) begin
                        midstate_q <= midstate;
                        nonce_q    <= '0;
                        addr_q     <= TAIL_ADDR;
                        state_q    <= S_RD0;
`ifdef NONCE_TARGET_CMP_EN
                        found_q       <= 1'b0;
                        found_nonce_q <= '0;
`endif
                    end
                end
                // Read data lags the address by one cycle, so each capture happens one state later.
                S_RD0: begin
                    addr_q  <= TAIL_ADDR + 16'd1;
                    state_q <= S_RD1;
                end
                S_RD1: begin
                    tail_q[0] <= mem_read_data;
                    addr_q    <= TAIL_ADDR + 16'd2;
                    state_q   <= S_RD2;
                end
                S_RD2: begin
                    tail_q[1] <= mem_read_data;
                    state_q   <= S_RDW;
                end
                S_RDW: begin
                    tail_q[2] <= mem_read_data;
                    hi_q      <= midstate_q;
                    phase_q   <= 1'b0;
                    cstart_q  <= 1'b1;
                    state_q   <= S_P2_GO;
                end
                S_P2_GO: begin
                    cstart_q <= 1'b0;
                    state_q  <= S_P2_WAIT;
                end
                S_P2_WAIT: begin
                    // The phase-2 digest lives in core_hi from here on; no separate copy is kept.
                    if (core_finish) begin
                        hi_q     <= core_ho;
                        phase_q  <= 1'b1;
                        cstart_q <= 1'b1;
                        state_q  <= S_P3_GO;
                    end
                end
                S_P3_GO: begin
                    cstart_q <= 1'b0;
                    state_q  <= S_P3_WAIT;
                end
                S_P3_WAIT: begin
                    if (core_finish) begin
                        wdata_q  <= core_ho[0];
                        addr_q   <= OUT_ADDR + {12'd0, nonce_q};
                        we_q     <= 1'b1;
                        cstart_q <= 1'b1;
                        state_q  <= S_WR;
                    end
                end
                S_WR: begin
                    we_q <= 1'b0;
`ifdef NONCE_TARGET_CMP_EN
                    if (!found_q && (wdata_q < target)) begin
                        found_q       <= 1'b1;
                        found_nonce_q <= nonce_q;
                    end
`endif
                    if (nonce_q == LAST_NONCE) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        nonce_q <= nonce_d;
                        hi_q    <= midstate_q;
                        phase_q <= 1'b0;
                        state_q <= S_P2_GO;
                    end
                end
                S_DONE: begin
                    done_q   <= 1'b0;
                    cstart_q <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: begin
                    cstart_q <= 1'b1;
                    we_q     <= 1'b0;
                    done_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign done           = done_q;
    assign mem_addr       = addr_q;
    assign mem_we         = we_q;
    assign mem_write_data = wdata_q;
    assign core_start     = cstart_q;
    assign core_phase_sel = phase_q;
    assign core_nonce     = nonce_q;
    assign core_hi        = hi_q;
    assign core_msg_tail  = tail_q;
`ifdef NONCE_TARGET_CMP_EN
    assign found          = found_q;
    assign found_nonce    = found_nonce_q;
`endif

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Randomized bench for nonce_sweep_ctrl with a stub hash core, a small memory and a sweep-level reference model.
module tb_nonce_sweep_ctrl;
    localparam int          N  = 16;
    localparam logic [15:0] TA = 16'd16;
    localparam logic [15:0] OA = 16'd32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [7:0][31:0] midstate = '0;
    logic             done;
    logic [15:0]      mem_addr;
    logic             mem_we;
    logic [31:0]      mem_write_data;
    logic [31:0]      mem_read_data = '0;
    logic             core_start;
    logic             core_phase_sel;
    logic [3:0]       core_nonce;
    logic [7:0][31:0] core_hi;
    logic [2:0][31:0] core_msg_tail;
    logic [7:0][31:0] core_ho;
    logic             core_finish = 1'b0;
`ifdef NONCE_TARGET_CMP_EN
    logic [31:0]      target = '0;
    logic             found;
    logic [3:0]       found_nonce;
`endif

    nonce_sweep_ctrl #(.NUM_NONCES(N), .TAIL_ADDR(TA), .OUT_ADDR(OA)) dut (
        .clk(clk), .reset(reset), .start(start), .midstate(midstate), .done(done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .core_start(core_start), .core_phase_sel(core_phase_sel),
        .core_nonce(core_nonce), .core_hi(core_hi), .core_msg_tail(core_msg_tail),
        .core_ho(core_ho), .core_finish(core_finish)
`ifdef NONCE_TARGET_CMP_EN
        , .target(target), .found(found), .found_nonce(found_nonce)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory with one-cycle read latency
    logic [31:0] mem [0:63];
    always @(posedge clk) mem_read_data <= mem[mem_addr[5:0]];

    // Stub core: digest = hi + 1, finish 5 cycles after start falls (never, when hang is set)
    logic hang = 1'b0;
    int   scnt = 0;
    always_comb begin
        for (int i = 0; i < 8; i++) core_ho[i] = core_hi[i] + 32'd1;
`ifdef NONCE_TARGET_CMP_EN
        core_ho[0] = core_hi[0] + 32'(core_nonce) + 32'd1;
`endif
    end
    always @(posedge clk) begin
        core_finish <= 1'b0;
        if (core_start) scnt <= 0;
        else if (scnt != 31) begin
            scnt <= scnt + 1;
            if (scnt == 4 && !hang) core_finish <= 1'b1;
        end
    end

    // Observation logs
    logic [15:0]      wa_q[$];
    logic [31:0]      wd_q[$];
    logic [4:0]       fin_q[$];
    int               done_cnt = 0;
    int               last_we_cyc = 0;
    int               done_cyc = 0;
    int               start_bad = 0;
    logic [2:0][31:0] tail_seen = '0;
    logic             tail_got = 1'b0;

    always @(negedge clk) begin
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_write_data);
            last_we_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (core_finish) begin
            fin_q.push_back({core_phase_sel, core_nonce});
            if (core_start) start_bad++;
            if (!tail_got) begin
                tail_seen = core_msg_tail;
                tail_got  = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_logs();
        wa_q.delete(); wd_q.delete(); fin_q.delete();
        done_cnt = 0; start_bad = 0; tail_got = 1'b0; tail_seen = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    // Reference: both hashes add 1 to word 0 (plus the nonce each time in target mode)
    function automatic logic [31:0] exp_word(input logic [31:0] m0, input int n);
`ifdef NONCE_TARGET_CMP_EN
        return m0 + 32'd2 + 32'(2 * n);
`else
        return m0 + 32'd2 + 32'(0 * n);
`endif
    endfunction

    task automatic run_sweep(input string tag, input logic [7:0][31:0] ms,
                             input logic [2:0][31:0] tail, input int mid_start_at);
        int k;
        for (int i = 0; i < 3; i++) mem[16 + i] = tail[i];
        clr_logs();
        midstate = ms;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        midstate = ~ms;
        k = 0;
        while (done_cnt == 0 && k < 3000) begin
            start = (k == mid_start_at);
            tick(1);
            k++;
        end
        start = 1'b0;
        tick(3);
        chk({tag, ".done_cnt"}, done_cnt, 1);
        chk({tag, ".writes"}, wa_q.size(), N);
        for (int i = 0; i < wa_q.size(); i++) begin
            chk($sformatf("%s.addr%0d", tag, i), wa_q[i], OA + 16'(i));
            chk($sformatf("%s.data%0d", tag, i), wd_q[i], exp_word(ms[0], i));
        end
        chk({tag, ".done_after_last"}, done_cyc - last_we_cyc, 1);
        chk({tag, ".finishes"}, fin_q.size(), 2 * N);
        for (int i = 0; i < fin_q.size(); i++)
            chk($sformatf("%s.phase_nonce%0d", tag, i), fin_q[i], {1'(i % 2), 4'(i / 2)});
        chk({tag, ".start_in_wait"}, start_bad, 0);
        for (int i = 0; i < 3; i++)
            chk($sformatf("%s.tail%0d", tag, i), tail_seen[i], tail[i]);
    endtask

    initial begin
        logic [7:0][31:0] ms;
        logic [2:0][31:0] tl;
        int k;
        int nw;
        for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD_0000 + 32'(i);
        tick(3);
        @(negedge clk);
        chk("rst.done", done, 0);
        chk("rst.mem_we", mem_we, 0);
        chk("rst.mem_addr", mem_addr, 0);
        chk("rst.wdata", mem_write_data, 0);
        chk("rst.core_start", core_start, 1);
        chk("rst.phase", core_phase_sel, 0);
        chk("rst.nonce", core_nonce, 0);
        chk("rst.hi0", core_hi[0], 0);
        chk("rst.tail0", core_msg_tail[0], 0);
        reset = 1'b0;
        tick(2);

        for (int i = 0; i < 8; i++) ms[i] = 32'h10;
        tl[0] = 32'hA; tl[1] = 32'hB; tl[2] = 32'hC;
        run_sweep("basic", ms, tl, -1);
        tick(5);
        run_sweep("midstart", ms, tl, 100);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) ms[i] = $urandom;
            for (int i = 0; i < 3; i++) tl[i] = $urandom;
            tick($urandom_range(1, 10));
            run_sweep($sformatf("rand%0d", r), ms, tl, $urandom_range(20, 200));
        end

        // Reset during nonce 5 phase-3 wait
        for (int i = 0; i < 3; i++) mem[16 + i] = tl[i];
        clr_logs();
        midstate = ms;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        k = 0;
        while (fin_q.size() < 11 && k < 2000) begin
            tick(1);
            k++;
        end
        chk("rstmid.reached", fin_q.size(), 11);
        tick(1);
        reset = 1'b1;
        tick(1);
        @(negedge clk);
        chk("rstmid.core_start", core_start, 1);
        chk("rstmid.mem_we", mem_we, 0);
        nw = wa_q.size();
        chk("rstmid.writes_before", nw, 5);
        tick(1);
        reset = 1'b0;
        tick(40);
        chk("rstmid.no_more_writes", wa_q.size(), nw);
        chk("rstmid.no_done", done_cnt, 0);
        run_sweep("after_rst", ms, tl, -1);

        // Core that never finishes
        hang = 1'b1;
        clr_logs();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(100);
        @(negedge clk);
        chk("hang.core_start", core_start, 0);
        chk("hang.done", done_cnt, 0);
        chk("hang.writes", wa_q.size(), 0);
        chk("hang.finishes", fin_q.size(), 0);
        do_reset();
        hang = 1'b0;

`ifdef NONCE_TARGET_CMP_EN
        for (int i = 0; i < 8; i++) ms[i] = 32'h0;
        target = 32'd4;
        run_sweep("tgt", ms, tl, -1);
        chk("tgt.found", found, 1);
        chk("tgt.found_nonce", found_nonce, 0);
        target = 32'd0;
        run_sweep("tgt_clear", ms, tl, -1);
        chk("tgt_clear.found", found, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d expected=done", cyc);
        $fatal(1, "global timeout");
    end
endmodule

// File: doc/nonce_sweep_ctrl.md
Name: nonce_sweep_ctrl

Overview:
- Upstream controller for the phase-2/phase-3 SHA-256 core (`simplified_sha256`) in the bitcoin hashing datapath.
- Reads the 3 header tail words (words 16..18) from shared memory and accepts the phase-1 midstate from its port.
- Runs a double hash on the core for every nonce 0..NUM_NONCES-1: phase 2 (midstate + tail + nonce), then phase 3 (re-hash of the phase-2 digest).
- Writes digest word 0 for each nonce to consecutive memory locations, then pulses done.

Parameters:
- NUM_NONCES, 16, number of nonces swept (1..16; the core nonce is 4 bits).
- TAIL_ADDR, 16'd16, memory address of header word 16; words 17 and 18 follow.
- OUT_ADDR, 16'd32, memory address of the result for nonce 0; nonce n goes to OUT_ADDR+n.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; ignored unless in IDLE.
- midstate  in  32x8  phase-1 digest; sampled on the cycle start is accepted.
- done  out  1  one-cycle pulse when the last result write completes.
- mem_addr  out  16  memory address.
- mem_we  out  1  memory write enable.
- mem_write_data  out  32  memory write data.
- mem_read_data  in  32  memory read data; valid one cycle after the address is presented.
- core_start  out  1  core hold/restart; high = core held at round 0 with state loaded from core_hi.
- core_phase_sel  out  1  0 = phase 2, 1 = phase 3.
- core_nonce  out  4  nonce for phase 2.
- core_hi  out  32x8  initial state to the core.
- core_msg_tail  out  32x3  header words 16..18.
- core_ho  in  32x8  core digest; valid when core_finish is high.
- core_finish  in  1  core completion pulse.

Behaviour:
- Reset values:
  - Outputs: done=0, mem_we=0, mem_addr=0, mem_write_data=0, core_start=1, core_phase_sel=0, core_nonce=0.
  - Internal: core_hi, core_msg_tail and the nonce counter cleared; state=IDLE.
- Reset mid-sweep: abandon the sweep immediately, issue no further writes, hold core_start high.
- States:
  - IDLE: core_start=1. On start, latch midstate, set nonce=0, go to RD0.
  - RD0/RD1/RD2: present TAIL_ADDR+0/+1/+2. Capture mem_read_data one cycle later into msg_tail[0..2]; the capture of word 2 happens in RDW.
  - RDW: capture the final word, go to P2_GO. Read phase is 4 cycles total.
  - P2_GO: set core_hi=midstate, core_phase_sel=0, core_nonce=nonce. Drive core_start=1 for exactly this cycle, then 0. Go to P2_WAIT.
  - P2_WAIT: core_start=0. On core_finish, latch core_ho into a digest register, go to P3_GO.
  - P3_GO: set core_hi=digest, core_phase_sel=1. One-cycle core_start=1. Go to P3_WAIT.
  - P3_WAIT: core_start=0. On core_finish, go to WR.
  - WR: mem_we=1 for one cycle, mem_addr=OUT_ADDR+nonce, mem_write_data=core_ho[0] latched at finish.
    - nonce==NUM_NONCES-1: go to DONE.
    - Otherwise: nonce+1, go to P2_GO.
  - DONE: done=1 for one cycle, core_start=1, return to IDLE.
- Core control rules:
  - core_phase_sel, core_hi and core_nonce stay stable from the GO cycle until the matching core_finish.
  - core_start is 0 throughout every WAIT state. The core self-restarts after finish unless held, so core_start returns to 1 in every non-WAIT state.
- No timeout. A missing core_finish hangs in WAIT until reset.
- start while busy is ignored; done is never asserted while busy.
- Address arithmetic is 16-bit and wraps modulo 2^16.
- mem_we is asserted only in WR, exactly NUM_NONCES times per sweep.

Optional Feature:
- Macro NONCE_TARGET_CMP_EN.
- When defined:
  - Added ports: target in 32; found out 1; found_nonce out 4.
  - In WR, if digest word 0 < target (unsigned) and found==0, set found=1 and found_nonce=nonce.
  - found and found_nonce are cleared on reset and on start acceptance, and hold their values after done.
  - The sweep always completes all nonces (no early exit).
- When undefined: no added ports or logic.

Test Plan:
- Stub core (ho[i]=hi[i]+1, finish 5 cycles after start falls), NUM_NONCES=16, midstate all 32'h10 -> 16 writes to addresses 32..47, each data 32'h12; exactly one done pulse after the last write.
- Memory words 16..18 = 32'hA, 32'hB, 32'hC -> core_msg_tail = {A, B, C} at the first P2_GO; core_nonce steps 0..15 across the sweep; core_phase_sel alternates 0/1 per nonce.
- Reset asserted during nonce 5 P3_WAIT -> no further mem_we; core_start=1 next cycle; a new start after reset writes from address 32 again.
- start pulsed mid-sweep -> ignored: write count stays 16 and midstate unchanged.
- Stub core never asserts finish -> block stays in P2_WAIT with core_start=0 and done=0 indefinitely.
- NONCE_TARGET_CMP_EN, stub ho[0]=hi[0]+nonce+1, midstate[0]=0, target=4 -> found=1, found_nonce=0 (digest 2<4); later nonces below target do not change found_nonce.
